// File: rtl/key_eeprom_reader_if.sv
// key_eeprom_reader_if: key-load request port and SPI EEPROM bus of the key reader.
interface key_eeprom_reader_if;
   logic       key_load_req;
   logic [6:0] key_addr;
   logic [7:0] key_data;
   logic       key_data_valid;
   logic       busy;
   logic       spi_cs_n;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_miso;
   modport slave (
      input  key_load_req, key_addr, spi_miso,
      output key_data, key_data_valid, busy, spi_cs_n, spi_sck, spi_mosi
   );
   modport master (
      output key_load_req, key_addr, spi_miso,
      input  key_data, key_data_valid, busy, spi_cs_n, spi_sck, spi_mosi
   );
endinterface

// File: rtl/key_eeprom_reader.sv
// key_eeprom_reader: turns a key byte request into one SPI mode-0 READ (0x03) of a 25xx EEPROM.
module key_eeprom_reader #(
   parameter int         CLK_DIV  = 4,
   parameter logic [7:0] KEY_BASE = 8'h00,
   parameter int         CS_IDLE  = 2
) (
   input logic               clk,
   input logic               rst_n,
   key_eeprom_reader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
   localparam int MC = CLK_DIV > CS_IDLE ? CLK_DIV : CS_IDLE;
   localparam int CW = $clog2(MC + 1);
   state_t        state;
   logic [CW-1:0] cnt;
   logic [5:0]    tcnt;
   logic [23:0]   sh;
   logic [7:0]    rx;
   logic [7:0]    addr;
   logic [23:0]   word;
   assign addr = KEY_BASE + {1'b0, bus.key_addr};
   assign word = {8'h03, addr, 8'h00};
   // cnt is shared: SCK half-period timer in SHIFT, CS-high timer in GAP
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state              <= IDLE;
         cnt                <= '0;
         tcnt               <= '0;
         sh                 <= '0;
         rx                 <= '0;
         bus.spi_cs_n       <= 1'b1;
         bus.spi_sck        <= 1'b0;
         bus.spi_mosi       <= 1'b0;
         bus.key_data       <= 8'h00;
         bus.key_data_valid <= 1'b0;
         bus.busy           <= 1'b0;
      end else begin
         bus.key_data_valid <= 1'b0;
         case (state)
            IDLE:
               if (bus.key_load_req) begin
                  state        <= SHIFT;
                  sh           <= word;
                  bus.spi_mosi <= word[23];
                  bus.spi_cs_n <= 1'b0;
                  bus.busy     <= 1'b1;
                  cnt          <= '0;
                  tcnt         <= '0;
               end
            SHIFT:
               if (cnt == CW'(CLK_DIV - 1)) begin
                  cnt         <= '0;
                  tcnt        <= tcnt + 6'd1;
                  bus.spi_sck <= ~bus.spi_sck;
                  if (!bus.spi_sck) begin
                     // only the last eight SCK periods carry EEPROM data
                     if (tcnt >= 6'd32) rx <= {rx[6:0], bus.spi_miso};
                  end else if (tcnt == 6'd47) begin
                     state              <= GAP;
                     bus.spi_cs_n       <= 1'b1;
                     bus.spi_mosi       <= 1'b0;
                     bus.key_data       <= rx;
                     bus.key_data_valid <= 1'b1;
                  end else begin
                     sh           <= {sh[22:0], 1'b0};
                     bus.spi_mosi <= sh[22];
                  end
               end else cnt <= cnt + 1'b1;
            GAP:
               if (cnt == CW'(CS_IDLE - 1)) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_key_eeprom_reader.sv
// tb_key_eeprom_reader: two readers (base 0x00 / div 2 / gap 2 and base 0xF8 / div 1 / gap 1)
// each talking to a behavioural 25xx EEPROM model.
module tb_key_eeprom_reader;
   localparam int CD0 = 2, CI0 = 2, CD1 = 1, CI1 = 1;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   key_eeprom_reader_if b0 ();
   key_eeprom_reader_if b1 ();
   key_eeprom_reader #(.CLK_DIV(CD0), .KEY_BASE(8'h00), .CS_IDLE(CI0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   key_eeprom_reader #(.CLK_DIV(CD1), .KEY_BASE(8'hF8), .CS_IDLE(CI1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   logic       req[2];
   logic [6:0] ad[2];
   logic       miso[2];
   logic       cs_o[2], sck_o[2], mosi_o[2], valid_o[2], busy_o[2];
   logic [7:0] data_o[2];
   assign b0.key_load_req = req[0];
   assign b1.key_load_req = req[1];
   assign b0.key_addr     = ad[0];
   assign b1.key_addr     = ad[1];
   assign b0.spi_miso     = miso[0];
   assign b1.spi_miso     = miso[1];
   assign cs_o[0]    = b0.spi_cs_n;
   assign cs_o[1]    = b1.spi_cs_n;
   assign sck_o[0]   = b0.spi_sck;
   assign sck_o[1]   = b1.spi_sck;
   assign mosi_o[0]  = b0.spi_mosi;
   assign mosi_o[1]  = b1.spi_mosi;
   assign valid_o[0] = b0.key_data_valid;
   assign valid_o[1] = b1.key_data_valid;
   assign busy_o[0]  = b0.busy;
   assign busy_o[1]  = b1.busy;
   assign data_o[0]  = b0.key_data;
   assign data_o[1]  = b1.key_data;

   // EEPROM contents and bus-side observations
   logic [7:0]  mem[2][256];
   logic [23:0] cmd[2];
   logic [7:0]  op[2], ea[2], vdata[2], cur;
   logic        pcs[2], psck[2];
   int          nb[2], acc_cyc[2], acc_n[2], vcnt[2], vcyc[2], hi_run[2], min_hi[2];
   int          cyc = 0;
   int          checks = 0, fails = 0, rq_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      for (int g = 0; g < 2; g++) begin
         if (cs_o[g]) begin
            nb[g] = 0;
            hi_run[g]++;
         end else begin
            if (pcs[g]) begin
               acc_cyc[g] = cyc;
               acc_n[g]++;
               if (hi_run[g] < min_hi[g]) min_hi[g] = hi_run[g];
               hi_run[g] = 0;
            end
            if (sck_o[g] && !psck[g]) begin
               cmd[g] = {cmd[g][22:0], mosi_o[g]};
               nb[g]++;
               if (nb[g] == 16) begin
                  op[g] = cmd[g][15:8];
                  ea[g] = cmd[g][7:0];
               end
            end
            // the EEPROM shifts out data bits on SCK falling edges after the address
            if (!sck_o[g] && psck[g] && nb[g] >= 16 && nb[g] < 24) begin
               cur     = mem[g][ea[g]];
               miso[g] = cur[23 - nb[g]];
            end
         end
         if (valid_o[g]) begin
            vcnt[g]++;
            vcyc[g]  = cyc;
            vdata[g] = data_o[g];
         end
         pcs[g]  = cs_o[g];
         psck[g] = sck_o[g];
      end

   function automatic int cdiv(input int g);
      return g ? CD1 : CD0;
   endfunction
   function automatic logic [7:0] base(input int g);
      return g ? 8'hF8 : 8'h00;
   endfunction

   task automatic check(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic wait_valid(input int g, input int n0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (vcnt[g] != n0) ok = 1'b1;
      end
      if (!ok) check("valid_timeout", 0, 1);
   endtask

   task automatic wait_acc(input int g, input int n0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (acc_n[g] != n0) ok = 1'b1;
      end
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic do_read(input int g, input logic [6:0] a, input logic [7:0] exp_d, input logic [7:0] exp_ab);
      bit ok;
      int n0;
      n0     = vcnt[g];
      rq_cyc = cyc;
      req[g] = 1'b1;
      ad[g]  = a;
      wait_valid(g, n0, ok);
      req[g] = 1'b0;
      if (ok) begin
         check("data", vdata[g], exp_d);
         check("latency", vcyc[g] - acc_cyc[g], 48 * cdiv(g));
         check("cs_high_at_valid", cs_o[g], 1);
         check("opcode", op[g], 8'h03);
         check("addr_byte", ea[g], exp_ab);
         check("data_phase_mosi", cmd[g][7:0], 8'h00);
         @(negedge clk);
         #1;
         check("valid_width", valid_o[g], 0);
      end
   endtask

   typedef struct {
      int         g;
      logic [6:0] a;
      logic [7:0] d;
      logic [7:0] ab;
   } vec_t;
   vec_t tbl[19];

   logic [127:0] pskw = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   logic [7:0]   psk[16];

   initial begin
      bit         ok;
      int         n0, a0, v1, lowc, g;
      logic [6:0] ra;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; ad[i] = '0; miso[i] = 1'b0; cmd[i] = '0; op[i] = '0; ea[i] = '0;
         vdata[i] = '0; pcs[i] = 1'b1; psck[i] = 1'b0; nb[i] = 0; acc_cyc[i] = 0; acc_n[i] = 0;
         vcnt[i] = 0; vcyc[i] = 0; hi_run[i] = 0; min_hi[i] = 1 << 30;
         for (int j = 0; j < 256; j++) mem[i][j] = 8'($urandom);
      end
      for (int i = 0; i < 16; i++) begin
         psk[i] = pskw[127 - 8*i -: 8];
         mem[0][i] = psk[i];
         mem[1][8'(8'hF8 + i)] = psk[i];
         tbl[i] = '{0, 7'(i), psk[i], 8'(i)};
      end
      tbl[16] = '{1, 7'h0A, psk[10], 8'h02};
      tbl[17] = '{1, 7'h07, psk[7], 8'hFF};
      tbl[18] = '{1, 7'h08, psk[8], 8'h00};

      repeat (3) @(negedge clk);
      #1;
      check("rst_cs_n", cs_o[0], 1);
      check("rst_sck", sck_o[0], 0);
      check("rst_mosi", mosi_o[0], 0);
      check("rst_key_data", data_o[0], 0);
      check("rst_valid", valid_o[0], 0);
      check("rst_busy", busy_o[0], 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // single read straight out of reset
      do_read(0, 7'd0, 8'h2b, 8'h00);
      check("first_accept_edge", acc_cyc[0], rq_cyc + 1);

      // full key plus wrapped addresses from the table
      for (int i = 0; i < 19; i++) do_read(tbl[i].g, tbl[i].a, tbl[i].d, tbl[i].ab);

      // held request: two back-to-back reads of the same byte
      n0 = vcnt[0];
      a0 = acc_n[0];
      req[0] = 1'b1;
      ad[0]  = 7'd3;
      wait_valid(0, n0, ok);
      if (ok) begin
         v1 = vcyc[0];
         check("held_data1", vdata[0], psk[3]);
         lowc = 0;
         for (int i = 0; i < 100 && acc_n[0] == a0 + 1; i++) begin
            @(negedge clk);
            #1;
            if (!busy_o[0]) lowc++;
         end
         check("held_reaccept_gap", acc_cyc[0] - v1, CI0 + 1);
         check("held_busy_low_cycles", lowc, 1);
         wait_valid(0, n0 + 1, ok);
         req[0] = 1'b0;
         check("held_data2", vdata[0], psk[3]);
         repeat (200) @(negedge clk);
         #1;
         check("held_valid_count", vcnt[0] - n0, 2);
         check("held_accept_count", acc_n[0] - a0, 2);
      end
      req[0] = 1'b0;

      // address change after accept must not affect the transaction
      n0 = vcnt[0];
      a0 = acc_n[0];
      req[0] = 1'b1;
      ad[0]  = 7'd4;
      wait_acc(0, a0, ok);
      repeat (20) @(negedge clk);
      ad[0] = 7'd9;
      wait_valid(0, n0, ok);
      req[0] = 1'b0;
      check("latched_addr_byte", ea[0], 8'h04);
      check("latched_data", vdata[0], psk[4]);

      // reset in SCK period 10
      repeat (10) @(negedge clk);
      n0 = vcnt[0];
      req[0] = 1'b1;
      ad[0]  = 7'd5;
      for (int i = 0; i < 1000 && nb[0] < 10; i++) @(negedge clk);
      check("reached_period10", nb[0], 10);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cs_n", cs_o[0], 1);
      check("midrst_sck", sck_o[0], 0);
      check("midrst_busy", busy_o[0], 0);
      check("midrst_key_data", data_o[0], 0);
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      #1;
      check("midrst_no_valid", vcnt[0] - n0, 0);
      do_read(0, 7'd5, psk[5], 8'h05);

      // randomized reads against the memory model
      for (int i = 0; i < 24; i++) begin
         g  = int'($urandom_range(0, 1));
         ra = 7'($urandom_range(0, 127));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         #1;
         do_read(g, ra, mem[g][8'(base(g) + {1'b0, ra})], 8'(base(g) + {1'b0, ra}));
      end

      check("min_cs_high_bus0", int'(min_hi[0] >= CI0), 1);
      check("min_cs_high_bus1", int'(min_hi[1] >= CI1), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
